result_uart_tx: RTL and testbench
=================================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 1..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: result buffer entries, fixed at 4 for this release.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port res_valid, input, 1 bit: processor result on res_data is valid this cycle.
REQ-006 SHALL have port res_data, input, 8 bits: processor result byte (uo_out of the processor stage).
REQ-007 SHALL have port res_ready, output, 1 bit: buffer can accept a result this cycle.
REQ-008 SHALL have port tx, output, 1 bit: serial line, 8N1, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress (state not IDLE).
REQ-010 SHALL have port fifo_count, output, 3 bits: number of buffered, unsent results (0..4).
REQ-011 SHALL have port frames_sent, output, 8 bits: count of completed frames, wraps 255->0.

Function
REQ-012 SHALL accept a result (push) on a rising edge where res_valid=1 and res_ready=1; no push otherwise, and res_data SHALL be ignored.
REQ-013 SHALL drive res_ready=1 exactly when fifo_count<4; combinational from the registered count.
REQ-014 SHALL NOT allow pass-through: a push into a full buffer is impossible even if a pop occurs on the same edge.
REQ-015 SHALL store results in FIFO order, using 2-bit read/write pointers that wrap 3->0.
REQ-016 SHALL use FSM states IDLE, START, DATA, STOP, encoded in registers.
REQ-017 SHALL pop on an edge where state=IDLE and fifo_count!=0: load the head byte into the shift register, go to START, and clear the bit-timer.
REQ-018 SHALL, when push and pop share an edge, leave fifo_count unchanged and keep both entries correct.
REQ-019 SHALL drive tx as a register: 1 in IDLE and STOP, 0 in START, and shift-register bit 0 in DATA (LSB first).
REQ-020 SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a bit-timer counting 0..CLKS_PER_BIT-1.
REQ-021 SHALL go START->DATA after one bit time; in DATA, shift right once per bit time, and go DATA->STOP after 8 bits (3-bit bit index, 0..7).
REQ-022 SHALL go STOP->IDLE after one bit time and increment frames_sent (modulo 256) on that same edge.
REQ-023 SHALL have a latency from push to tx falling of exactly one clock edge when the buffer was empty and state=IDLE.
REQ-024 SHALL give each frame a duration of 10*CLKS_PER_BIT cycles; back-to-back frames are separated by exactly one extra cycle of IDLE with tx=1.
REQ-025 SHALL drive busy=1 in START, DATA and STOP, and busy=0 in IDLE.
REQ-026 SHALL NOT allow a change on res_valid or res_data to alter a frame already in progress.

Reset
REQ-027 SHALL, on an edge where rst=1, set state=IDLE, tx=1, busy=0, fifo_count=0, pointers=0, frames_sent=0, bit-timer=0 and shift register=0, taking priority over any push or pop on that edge.
REQ-028 SHALL, if reset occurs mid-frame, abort the frame, discard buffered results and not count the aborted frame; res_ready=1 the cycle after reset.

Verification
REQ-029 SHALL cover a single push: CLKS_PER_BIT=4, push 0x05 -> tx low one edge later; bits 1,0,1,0,0,0,0,0 each held 4 cycles; stop high; frames_sent=1 after 40 cycles.
REQ-030 SHALL cover a burst: push 0x05,0x05,0x06,0x09,0x00,0x02 on consecutive cycles with res_valid held -> 5 accepted by cycle 4, res_ready=0 at cycle 5, 6th accepted after first frame pop; tx order is 05,05,06,09,00,02; frames_sent=6.
REQ-031 SHALL cover a simultaneous push/pop: push on the same edge as the IDLE pop with fifo_count=1 -> fifo_count stays 1; both bytes sent in order.
REQ-032 SHALL cover reset mid-frame: assert rst during DATA bit 3 with fifo_count=2 -> next cycle tx=1, busy=0, fifo_count=0, frames_sent=0; no further frames.
REQ-033 SHALL cover frames_sent wrap: 256 completed frames -> frames_sent returns to 0.
REQ-034 SHALL cover CLKS_PER_BIT=1: push 0xFF -> frame of 10 cycles, tx pattern 0,1,1,1,1,1,1,1,1,1.

Source files
------------

// File: rtl/result_uart_tx.sv
// Result byte buffer (4-entry FIFO) feeding an 8N1 serial transmitter.
// Bytes are popped only between frames; tx is driven from a register.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    input  logic [7:0] res_data,
    output logic       res_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] fifo_count,
    output logic [7:0] frames_sent
);
    localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] FULL_CNT = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t     state, state_nxt;
    logic [7:0] bit_timer, timer_nxt;
    logic [2:0] bit_idx, idx_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       tx_nxt;
    logic       frame_done;

    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic       push, pop, bit_done;

    // Ready comes from the registered count only, so a pop never frees a
    // slot for a push on the same edge.
    assign res_ready = (fifo_count < FULL_CNT);
    assign push      = res_valid && res_ready;
    assign pop       = (state == IDLE) && (fifo_count != 3'd0);
    assign bit_done  = (bit_timer == BIT_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push && !rst)
            fifo_mem[wr_ptr] <= res_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_timer   <= 8'd0;
            bit_idx     <= 3'd0;
            shreg       <= 8'd0;
            tx          <= 1'b1;
            frames_sent <= 8'd0;
        end else begin
            state     <= state_nxt;
            bit_timer <= timer_nxt;
            bit_idx   <= idx_nxt;
            shreg     <= shreg_nxt;
            tx        <= tx_nxt;
            if (frame_done)
                frames_sent <= frames_sent + 8'd1;
        end
    end

    // tx_nxt is the line level for the state being entered, which keeps tx
    // registered without an extra cycle of latency.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = bit_timer;
        idx_nxt    = bit_idx;
        shreg_nxt  = shreg;
        tx_nxt     = tx;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (pop) begin
                    shreg_nxt = fifo_mem[rd_ptr];
                    timer_nxt = 8'd0;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_nxt = 8'd0;
                    idx_nxt   = 3'd0;
                    state_nxt = DATA;
                    tx_nxt    = shreg[0];
                end else begin
                    timer_nxt = bit_timer + 8'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_nxt = 8'd0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        idx_nxt   = bit_idx + 3'd1;
                        shreg_nxt = {1'b0, shreg[7:1]};
                        tx_nxt    = shreg[1];
                    end
                end else begin
                    timer_nxt = bit_timer + 8'd1;
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_done) begin
                    timer_nxt  = 8'd0;
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end else begin
                    timer_nxt = bit_timer + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx at CLKS_PER_BIT=4 and =1: a frame-timeline model
// predicts line/FIFO state, and a serial decoder pops expected bytes.
module tb_result_uart_tx;
    logic clk = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input int inst, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cpb%0d %s: got %0h expected %0h at %0t", inst, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int CPB = (g == 0) ? 4 : 1;
        localparam logic [7:0] ONE_BYTE = (CPB == 1) ? 8'hFF : 8'h05;

        logic       rst, res_valid, res_ready, tx, busy;
        logic [7:0] res_data, frames_sent;
        logic [2:0] fifo_count;

        result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
            .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
            .res_ready(res_ready), .tx(tx), .busy(busy),
            .fifo_count(fifo_count), .frames_sent(frames_sent)
        );

        // Model: each accepted byte starts its frame on the first edge after
        // both its push edge and the previous frame's end edge.
        int         cyc = 0;
        int         pend_t[$];
        logic [7:0] pend_b[$];
        logic [7:0] sb[$];
        bit         cur_on = 0;
        int         cur_s = 0;
        logic [7:0] cur_b = 8'd0;
        int         m_frames = 0;
        int         total_acc = 0;
        bit         acc = 0;
        bit         armed = 0;
        bit         done = 0;

        always @(posedge clk) begin
            acc = 0;
            if (rst) begin
                pend_t.delete();
                pend_b.delete();
                sb.delete();
                cur_on = 0;
                m_frames = 0;
                total_acc = 0;
                armed = 1;
            end else begin
                if (res_valid && pend_t.size() < 4) begin
                    pend_t.push_back(cyc);
                    pend_b.push_back(res_data);
                    sb.push_back(res_data);
                    acc = 1;
                    total_acc++;
                end
                if (cur_on) begin
                    if (cyc == cur_s + 10 * CPB) begin
                        cur_on = 0;
                        m_frames = (m_frames + 1) % 256;
                    end
                end else if (pend_t.size() > 0 && pend_t[0] < cyc) begin
                    cur_on = 1;
                    cur_s = cyc;
                    cur_b = pend_b.pop_front();
                    void'(pend_t.pop_front());
                end
            end
            cyc++;
        end

        always @(negedge clk) begin
            int   o, b;
            logic ex;
            if (armed) begin
                ex = 1'b1;
                if (cur_on) begin
                    o = cyc - 1 - cur_s;
                    b = o / CPB;
                    if (b == 0)
                        ex = 1'b0;
                    else if (b <= 8)
                        ex = cur_b[b-1];
                end
                chk(CPB, "tx", 32'(tx), 32'(ex));
                chk(CPB, "busy", 32'(busy), 32'(cur_on));
                chk(CPB, "fifo_count", 32'(fifo_count), 32'(pend_t.size()));
                chk(CPB, "res_ready", 32'(res_ready), 32'(pend_t.size() < 4));
                chk(CPB, "frames_sent", 32'(frames_sent), 32'(m_frames));
            end
        end

        // Serial decoder: samples each bit at its first cycle, then pops the
        // scoreboard at the stop bit.
        bit         mon_on = 0;
        int         mon_off = 0;
        logic [7:0] mon_b = 8'd0;

        always @(negedge clk) begin
            int k;
            if (rst || !armed) begin
                mon_on = 0;
            end else if (!mon_on) begin
                if (tx === 1'b0) begin
                    mon_on = 1;
                    mon_off = 0;
                end
            end else begin
                mon_off++;
                if (mon_off % CPB == 0) begin
                    k = mon_off / CPB;
                    if (k >= 1 && k <= 8) begin
                        mon_b[k-1] = tx;
                    end else if (k == 9) begin
                        chk(CPB, "stop_bit", 32'(tx), 32'd1);
                        chk(CPB, "frame_expected", 32'(sb.size() > 0), 32'd1);
                        if (sb.size() > 0)
                            chk(CPB, "frame_byte", 32'(mon_b), 32'(sb.pop_front()));
                        mon_on = 0;
                    end
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic push1(input logic [7:0] d);
            res_valid = 1'b1;
            res_data  = d;
            for (int k = 0; k < 300; k++) begin
                step();
                if (acc) break;
            end
            chk(CPB, "push_accepted", 32'(acc), 32'd1);
            res_valid = 1'b0;
        endtask

        task automatic drain();
            for (int k = 0; k < 3000; k++) begin
                if (!cur_on && pend_t.size() == 0) break;
                step();
            end
            chk(CPB, "drain_idle", 32'(cur_on || pend_t.size() > 0), 32'd0);
        endtask

        initial begin
            logic [7:0] bb [6];
            bb = '{8'h05, 8'h05, 8'h06, 8'h09, 8'h00, 8'h02};
            rst = 1'b1;
            res_valid = 1'b0;
            res_data = 8'd0;
            repeat (3) step();
            rst = 1'b0;

            // single push: line falls one edge later
            push1(ONE_BYTE);
            step();
            chk(CPB, "first_edge_tx", 32'(tx), 32'd0);
            drain();
            chk(CPB, "single_frames", 32'(frames_sent), 32'd1);

            // burst with valid held; fifth accept fills the buffer
            for (int i = 0; i < 6; i++) begin
                push1(bb[i]);
                if (i == 4) begin
                    chk(CPB, "burst_full_ready", 32'(res_ready), 32'd0);
                    chk(CPB, "burst_full_count", 32'(fifo_count), 32'd4);
                end
            end
            drain();
            chk(CPB, "burst_frames", 32'(frames_sent), 32'd7);

            // push on the same edge as the idle pop
            push1(8'hA5);
            push1(8'h3C);
            chk(CPB, "pushpop_count", 32'(fifo_count), 32'd1);
            drain();

            repeat (400) begin
                res_valid = ($urandom_range(0, 3) == 0);
                res_data  = 8'($urandom);
                step();
            end
            res_valid = 1'b0;
            drain();

            // reset in the middle of data bit 3 with two bytes still queued
            push1(8'h5A);
            push1(8'h11);
            push1(8'h22);
            for (int k = 0; k < 100; k++) begin
                if (cur_on && (cyc - 1 - cur_s) == 4 * CPB + CPB / 2 - 1) break;
                step();
            end
            chk(CPB, "pre_reset_count", 32'(fifo_count), 32'd2);
            res_valid = 1'b1;
            res_data  = 8'hEE;
            rst = 1'b1;
            step();
            rst = 1'b0;
            res_valid = 1'b0;
            chk(CPB, "rst_tx", 32'(tx), 32'd1);
            chk(CPB, "rst_busy", 32'(busy), 32'd0);
            chk(CPB, "rst_count", 32'(fifo_count), 32'd0);
            chk(CPB, "rst_frames", 32'(frames_sent), 32'd0);
            chk(CPB, "rst_ready", 32'(res_ready), 32'd1);
            repeat (60) step();

            // 256 frames bring the counter back to zero
            res_valid = 1'b1;
            for (int k = 0; k < 20000 && total_acc < 256; k++) begin
                res_data = 8'($urandom);
                step();
            end
            res_valid = 1'b0;
            drain();
            chk(CPB, "wrap_frames", 32'(frames_sent), 32'd0);
            repeat (5) step();
            chk(CPB, "scoreboard_empty", 32'(sb.size()), 32'd0);
            done = 1;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        wait (u[0].done && u[1].done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
